// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU opcodes and forward-select codes.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_NOP = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_AND = 4'h3;
    localparam logic [3:0] ALU_OR  = 4'h4;
    localparam logic [3:0] ALU_SLL = 4'h5;
    localparam logic [3:0] ALU_SRL = 4'h6;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding for one source register: pick EX/MEM, MEM/WB or the register-file value.
module fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] regval,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] value
);

    fwd_sel_e sel;

    // The younger producer (EX/MEM) shadows MEM/WB; r0 is hard-wired and never forwarded.
    always_comb begin
        sel = FWD_NONE;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src))
            sel = FWD_EXMEM;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src))
            sel = FWD_MEMWB;
    end

    always_comb begin
        value = regval;
        case (sel)
            FWD_EXMEM: value = exmem_result;
            FWD_MEMWB: value = memwb_result;
            default:   value = regval;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and forwarded ALU operands.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [DW-1:0] id_pc_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    input  logic [RW-1:0] id_rd_i,
    input  logic [DW-1:0] id_imm_i,
    input  logic [4:0]    id_shamt_i,
    input  logic [3:0]    id_aluop_i,
    input  logic          id_alusrc_i,
    input  logic          id_shsrc_i,
    input  logic          id_regwrite_i,
    input  logic          id_memread_i,
    input  logic          id_memwrite_i,
    input  logic          id_mem2reg_i,
    input  logic          exmem_regwrite_i,
    input  logic [RW-1:0] exmem_rd_i,
    input  logic [DW-1:0] exmem_result_i,
    input  logic          memwb_regwrite_i,
    input  logic [RW-1:0] memwb_rd_i,
    input  logic [DW-1:0] memwb_result_i,
    output logic          ex_valid_o,
    output logic [DW-1:0] ex_A_o,
    output logic [DW-1:0] ex_B_o,
    output logic [3:0]    ex_aluop_o,
    output logic [DW-1:0] ex_store_o,
    output logic [RW-1:0] ex_rd_o,
    output logic [DW-1:0] ex_pc_o,
    output logic          ex_regwrite_o,
    output logic          ex_memread_o,
    output logic          ex_memwrite_o,
    output logic          ex_mem2reg_o,
    output logic          load_use_stall_o
);

    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_rs_data;
    logic [DW-1:0] ex_rt_data;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [RW-1:0] ex_rd;
    logic [DW-1:0] ex_imm;
    logic [4:0]    ex_shamt;
    logic [3:0]    ex_aluop;
    logic          ex_alusrc;
    logic          ex_shsrc;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_mem2reg;
    logic          load_bubble;
    logic          load_id;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    // A load in EX whose destination is read by the instruction in ID cannot be forwarded in time.
    assign load_use_stall_o = ex_valid && ex_memread && (ex_rd != '0) && id_valid_i
                              && ((ex_rd == id_rs_i) || (ex_rd == id_rt_i));

    assign load_bubble = flush_i || (!stall_i && load_use_stall_o);
    assign load_id     = !flush_i && !stall_i && !load_use_stall_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || load_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_imm      <= '0;
            ex_shamt    <= '0;
            ex_aluop    <= ALU_NOP;
            ex_alusrc   <= 1'b0;
            ex_shsrc    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_mem2reg  <= 1'b0;
        end else if (load_id) begin
            ex_valid    <= id_valid_i;
            ex_pc       <= id_pc_i;
            ex_rs_data  <= id_rs_data_i;
            ex_rt_data  <= id_rt_data_i;
            ex_rs       <= id_rs_i;
            ex_rt       <= id_rt_i;
            ex_rd       <= id_rd_i;
            ex_imm      <= id_imm_i;
            ex_shamt    <= id_shamt_i;
            ex_aluop    <= id_aluop_i;
            ex_alusrc   <= id_alusrc_i;
            ex_shsrc    <= id_shsrc_i;
            ex_regwrite <= id_regwrite_i;
            ex_memread  <= id_memread_i;
            ex_memwrite <= id_memwrite_i;
            ex_mem2reg  <= id_mem2reg_i;
        end
    end

    fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src            (ex_rs),
        .regval         (ex_rs_data),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_rd       (exmem_rd_i),
        .exmem_result   (exmem_result_i),
        .memwb_regwrite (memwb_regwrite_i),
        .memwb_rd       (memwb_rd_i),
        .memwb_result   (memwb_result_i),
        .value          (rs_fwd)
    );

    fwd_unit #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src            (ex_rt),
        .regval         (ex_rt_data),
        .exmem_regwrite (exmem_regwrite_i),
        .exmem_rd       (exmem_rd_i),
        .exmem_result   (exmem_result_i),
        .memwb_regwrite (memwb_regwrite_i),
        .memwb_rd       (memwb_rd_i),
        .memwb_result   (memwb_result_i),
        .value          (rt_fwd)
    );

    assign ex_A_o        = ex_shsrc ? {{(DW-5){1'b0}}, ex_shamt} : rs_fwd;
    assign ex_B_o        = ex_alusrc ? ex_imm : rt_fwd;
    assign ex_store_o    = rt_fwd;
    assign ex_valid_o    = ex_valid;
    assign ex_aluop_o    = ex_aluop;
    assign ex_rd_o       = ex_rd;
    assign ex_pc_o       = ex_pc;
    assign ex_regwrite_o = ex_regwrite;
    assign ex_memread_o  = ex_memread;
    assign ex_memwrite_o = ex_memwrite;
    assign ex_mem2reg_o  = ex_mem2reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random checks of id_ex_stage against a behavioural model of the latched instruction.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        rstn;
    logic        stall_i, flush_i, id_valid_i;
    logic [31:0] id_pc_i, id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_rs_i, id_rt_i, id_rd_i, id_shamt_i;
    logic [3:0]  id_aluop_i;
    logic        id_alusrc_i, id_shsrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_mem2reg_i;
    logic        exmem_regwrite_i, memwb_regwrite_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_result_i, memwb_result_i;
    logic        ex_valid_o;
    logic [31:0] ex_A_o, ex_B_o, ex_store_o, ex_pc_o;
    logic [3:0]  ex_aluop_o;
    logic [4:0]  ex_rd_o;
    logic        ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_mem2reg_o, load_use_stall_o;

    int assertions = 0;
    int failures   = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic [3:0]  aluop;
        logic        alusrc, shsrc, regwrite, memread, memwrite, mem2reg;
    } ex_model_t;

    ex_model_t m;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rstn(rstn), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_rs_data_i(id_rs_data_i),
        .id_rt_data_i(id_rt_data_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
        .id_imm_i(id_imm_i), .id_shamt_i(id_shamt_i), .id_aluop_i(id_aluop_i),
        .id_alusrc_i(id_alusrc_i), .id_shsrc_i(id_shsrc_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i), .id_mem2reg_i(id_mem2reg_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
        .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
        .ex_valid_o(ex_valid_o), .ex_A_o(ex_A_o), .ex_B_o(ex_B_o), .ex_aluop_o(ex_aluop_o),
        .ex_store_o(ex_store_o), .ex_rd_o(ex_rd_o), .ex_pc_o(ex_pc_o),
        .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o),
        .ex_mem2reg_o(ex_mem2reg_o), .load_use_stall_o(load_use_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ex_model_t bubble();
        ex_model_t b;
        b       = '0;
        b.aluop = ALU_NOP;
        return b;
    endfunction

    // The value an instruction actually sees for register r, given what is in flight.
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
        if (exmem_regwrite_i && exmem_rd_i != 0 && exmem_rd_i == r) return exmem_result_i;
        if (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == r) return memwb_result_i;
        return v;
    endfunction

    function automatic logic expLoadUse();
        return m.valid && m.memread && m.rd != 0 && id_valid_i
               && (m.rd == id_rs_i || m.rd == id_rt_i);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assertions++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkVal("valid",    32'(ex_valid_o),    32'(m.valid));
        checkVal("A",        ex_A_o,   m.shsrc ? {27'b0, m.shamt} : fwd(m.rs, m.rs_data));
        checkVal("B",        ex_B_o,   m.alusrc ? m.imm : fwd(m.rt, m.rt_data));
        checkVal("store",    ex_store_o, fwd(m.rt, m.rt_data));
        checkVal("aluop",    32'(ex_aluop_o),    32'(m.aluop));
        checkVal("rd",       32'(ex_rd_o),       32'(m.rd));
        checkVal("pc",       ex_pc_o,  m.pc);
        checkVal("regwrite", 32'(ex_regwrite_o), 32'(m.regwrite));
        checkVal("memread",  32'(ex_memread_o),  32'(m.memread));
        checkVal("memwrite", 32'(ex_memwrite_o), 32'(m.memwrite));
        checkVal("mem2reg",  32'(ex_mem2reg_o),  32'(m.mem2reg));
        checkVal("loaduse",  32'(load_use_stall_o), 32'(expLoadUse()));
    endtask

    // One clock edge: the model follows flush > stall > load-use > capture, then inputs may change.
    task automatic applyStimulus();
        logic luse;
        @(posedge clk);
        luse = expLoadUse();
        if (flush_i)       m = bubble();
        else if (stall_i)  m = m;
        else if (luse)     m = bubble();
        else begin
            m.valid = id_valid_i;   m.pc = id_pc_i;       m.rs_data = id_rs_data_i;
            m.rt_data = id_rt_data_i; m.imm = id_imm_i;   m.rs = id_rs_i;
            m.rt = id_rt_i;         m.rd = id_rd_i;       m.shamt = id_shamt_i;
            m.aluop = id_aluop_i;   m.alusrc = id_alusrc_i; m.shsrc = id_shsrc_i;
            m.regwrite = id_regwrite_i; m.memread = id_memread_i;
            m.memwrite = id_memwrite_i; m.mem2reg = id_mem2reg_i;
        end
        #1;
    endtask

    task automatic clearInputs();
        stall_i = 0; flush_i = 0; id_valid_i = 0; id_pc_i = 0; id_rs_data_i = 0; id_rt_data_i = 0;
        id_imm_i = 0; id_rs_i = 0; id_rt_i = 0; id_rd_i = 0; id_shamt_i = 0; id_aluop_i = ALU_NOP;
        id_alusrc_i = 0; id_shsrc_i = 0; id_regwrite_i = 0; id_memread_i = 0; id_memwrite_i = 0;
        id_mem2reg_i = 0; exmem_regwrite_i = 0; exmem_rd_i = 0; exmem_result_i = 0;
        memwb_regwrite_i = 0; memwb_rd_i = 0; memwb_result_i = 0;
    endtask

    initial begin
        logic [3:0] ops [7];
        ops = '{ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRL};

        clearInputs();
        rstn = 0;
        m = bubble();
        #3;
        checkOutput();
        checkVal("reset_aluop", 32'(ex_aluop_o), 32'(ALU_NOP));
        #4 rstn = 1;

        // EX/MEM forwarding, then MEM/WB-only forwarding
        id_valid_i = 1; id_pc_i = 32'h100; id_rs_i = 3; id_rt_i = 3; id_rd_i = 4;
        id_rs_data_i = 32'hAAAA; id_rt_data_i = 32'hBBBB; id_aluop_i = ALU_ADD; id_regwrite_i = 1;
        exmem_regwrite_i = 1; exmem_rd_i = 3; exmem_result_i = 32'h10;
        applyStimulus();
        #1 checkOutput();
        checkVal("fwd_exmem_A", ex_A_o, 32'h10);
        checkVal("fwd_exmem_B", ex_B_o, 32'h10);
        exmem_regwrite_i = 0; memwb_regwrite_i = 1; memwb_rd_i = 3; memwb_result_i = 32'h20;
        #1 checkOutput();
        checkVal("fwd_memwb_A", ex_A_o, 32'h20);
        checkVal("fwd_memwb_B", ex_B_o, 32'h20);

        // EX/MEM beats MEM/WB; r0 is never forwarded
        id_rs_i = 5; id_rt_i = 5;
        exmem_regwrite_i = 1; exmem_rd_i = 5; exmem_result_i = 32'h1; memwb_rd_i = 5; memwb_result_i = 32'h2;
        applyStimulus();
        #1 checkOutput();
        checkVal("prio_A", ex_A_o, 32'h1);
        id_rs_i = 0; id_rt_i = 0; id_rs_data_i = 32'h1234; id_rt_data_i = 32'h5678;
        exmem_rd_i = 0; exmem_result_i = 32'hDEAD; memwb_rd_i = 0; memwb_result_i = 32'hBEEF;
        applyStimulus();
        #1 checkOutput();
        checkVal("r0_A", ex_A_o, 32'h1234);
        checkVal("r0_B", ex_B_o, 32'h5678);

        // Asynchronous reset mid-cycle with a valid instruction in EX
        #2 rstn = 0;
        m = bubble();
        #1 checkOutput();
        checkVal("async_valid", 32'(ex_valid_o), 32'h0);
        checkVal("async_pc", ex_pc_o, 32'h0);
        id_pc_i = 32'h200;
        rstn = 1;
        #1 applyStimulus();
        #1 checkOutput();
        checkVal("post_reset_valid", 32'(ex_valid_o), 32'h1);
        checkVal("post_reset_pc", ex_pc_o, 32'h200);

        // Load-use: held under stall, then a bubble
        clearInputs();
        id_valid_i = 1; id_memread_i = 1; id_regwrite_i = 1; id_mem2reg_i = 1; id_rd_i = 2;
        id_aluop_i = ALU_ADD; id_pc_i = 32'h300; id_rs_i = 1; id_rt_i = 1;
        applyStimulus();
        id_rs_i = 2; id_rt_i = 7; id_rd_i = 9; id_pc_i = 32'h304; id_memread_i = 0; id_mem2reg_i = 0;
        #1 checkOutput();
        checkVal("loaduse_req", 32'(load_use_stall_o), 32'h1);
        stall_i = 1;
        applyStimulus();
        #1 checkOutput();
        checkVal("held_valid", 32'(ex_valid_o), 32'h1);
        checkVal("held_pc", ex_pc_o, 32'h300);
        stall_i = 0;
        applyStimulus();
        #1 checkOutput();
        checkVal("bubble_valid", 32'(ex_valid_o), 32'h0);
        checkVal("bubble_regwrite", 32'(ex_regwrite_o), 32'h0);
        checkVal("bubble_aluop", 32'(ex_aluop_o), 32'(ALU_NOP));
        applyStimulus();
        #1 checkOutput();
        checkVal("after_bubble_pc", ex_pc_o, 32'h304);

        // Shift amount on A, immediate on B with store data still forwarded
        clearInputs();
        id_valid_i = 1; id_shsrc_i = 1; id_shamt_i = 4; id_rt_i = 6; id_rt_data_i = 32'h99;
        id_aluop_i = ALU_SLL; id_regwrite_i = 1; id_rd_i = 8; id_pc_i = 32'h400;
        exmem_regwrite_i = 1; exmem_rd_i = 6; exmem_result_i = 32'h3;
        applyStimulus();
        #1 checkOutput();
        checkVal("sll_A", ex_A_o, 32'h4);
        checkVal("sll_B", ex_B_o, 32'h3);
        id_shsrc_i = 0; id_alusrc_i = 1; id_imm_i = 32'hFFFFFFFF; id_rs_i = 1; id_rs_data_i = 32'h7;
        id_rt_data_i = 32'h55; id_aluop_i = ALU_ADD;
        applyStimulus();
        #1 checkOutput();
        checkVal("addi_B", ex_B_o, 32'hFFFFFFFF);
        checkVal("addi_store", ex_store_o, 32'h3);

        // Flush overrides stall; a plain stall freezes EX
        flush_i = 1; stall_i = 1;
        applyStimulus();
        #1 checkOutput();
        checkVal("flush_valid", 32'(ex_valid_o), 32'h0);
        flush_i = 0; stall_i = 0; id_pc_i = 32'h500;
        applyStimulus();
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            id_pc_i = 32'h600 + 32'(i); id_rd_i = 5'(i + 10);
            applyStimulus();
            #1 checkOutput();
            checkVal("stall_pc", ex_pc_o, 32'h500);
        end
        stall_i = 0;

        // Random traffic with narrow register numbers so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            stall_i = ($urandom_range(0, 5) == 0);  flush_i = ($urandom_range(0, 7) == 0);
            id_valid_i = ($urandom_range(0, 4) != 0); id_pc_i = $urandom; id_imm_i = $urandom;
            id_rs_data_i = $urandom; id_rt_data_i = $urandom;
            id_rs_i = 5'($urandom_range(0, 3)); id_rt_i = 5'($urandom_range(0, 3));
            id_rd_i = 5'($urandom_range(0, 3)); id_shamt_i = 5'($urandom);
            id_aluop_i = ops[$urandom_range(0, 6)];
            id_alusrc_i = 1'($urandom); id_shsrc_i = 1'($urandom); id_regwrite_i = 1'($urandom);
            id_memread_i = 1'($urandom); id_memwrite_i = 1'($urandom); id_mem2reg_i = 1'($urandom);
            exmem_regwrite_i = 1'($urandom); exmem_rd_i = 5'($urandom_range(0, 3)); exmem_result_i = $urandom;
            memwb_regwrite_i = 1'($urandom); memwb_rd_i = 5'($urandom_range(0, 3)); memwb_result_i = $urandom;
            #1 checkOutput();
            applyStimulus();
        end
        #1 checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
